// File: rtl/irqc_pkg.sv
// ============================================================================
// Module   : irqc_pkg
// Purpose  : Shared register offsets, FSM states and CAUSE layout for irqc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irqc_pkg;

  localparam logic [1:0] OFF_PEND  = 2'd0;
  localparam logic [1:0] OFF_MASK  = 2'd1;
  localparam logic [1:0] OFF_CAUSE = 2'd2;
  localparam logic [1:0] OFF_EDGE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irqc_state_e;

  localparam int CAUSE_IC_LSB   = 0;
  localparam int CAUSE_IC_W     = 4;
  localparam int CAUSE_BUSY_BIT = 4;

  function automatic logic [15:0] causeWord(input logic busy, input logic [3:0] ic);
    logic [15:0] word;
    word = '0;
    word[CAUSE_IC_LSB +: CAUSE_IC_W] = ic;
    word[CAUSE_BUSY_BIT] = busy;
    return word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irqc_prio_enc.sv
// ============================================================================
// Module   : irqc_prio_enc
// Purpose  : Lowest-index-first priority encoder over the active requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irqc_prio_enc
  import irqc_pkg::*;
#(
  parameter int NSRC = 16
) (
  input  logic [NSRC-1:0] i_req,
  output logic            o_valid,
  output logic [3:0]      o_idx
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_valid = |i_req;
    o_idx   = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = 4'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Purpose  : Bus-mapped 16-source interrupt controller with ack/EOI handshake.
//            Optional IRQC_SYNC_EN adds a 2-flop synchronizer on every SRC bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller
  import irqc_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hFF00,
  parameter int          NSRC = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [15:0]     A,
  input  logic            W,
  inout  wire  [15:0]     D,
  input  logic [NSRC-1:0] SRC,
  output logic            IRQ,
  output logic [3:0]      IC
);

  localparam logic [15:0] VALID_MASK = 16'((32'h1 << NSRC) - 1);

  logic [15:0] r_pend;
  logic [15:0] r_mask;
  logic [15:0] r_edge;
  logic [15:0] r_prev;
  logic [3:0]  r_ic;
  irqc_state_e r_state;

  logic [15:0] w_srcRaw;
  logic [15:0] w_srcSmp;
  logic [15:0] w_active;
  logic [15:0] w_rise;
  logic [15:0] w_w1c;
  logic [15:0] w_ackClr;
  logic [15:0] w_pendNext;
  logic [15:0] w_rdData;
  logic [1:0]  w_off;
  logic        w_hit;
  logic        w_rdHit;
  logic        w_wrHit;
  logic        w_ack;
  logic        w_eoi;
  logic        w_valid;
  logic [3:0]  w_idx;

  always_comb begin
    w_srcRaw = '0;
    w_srcRaw[NSRC-1:0] = SRC;
  end

`ifdef IRQC_SYNC_EN
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_srcRaw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_srcSmp = r_sync2;
`else
  assign w_srcSmp = w_srcRaw;
`endif

  assign w_hit   = (A[15:2] == BASE[15:2]);
  assign w_off   = A[1:0];
  assign w_rdHit = w_hit & ~W;
  assign w_wrHit = w_hit & W;
  assign w_ack   = (r_state == REQ) && w_rdHit && (w_off == OFF_CAUSE);
  assign w_eoi   = (r_state == SERV) && w_wrHit && (w_off == OFF_CAUSE);

  assign w_active = r_pend & r_mask;
  assign w_rise   = w_srcSmp & ~r_prev & r_edge;
  assign w_w1c    = (w_wrHit && (w_off == OFF_PEND)) ? D : 16'h0000;
  assign w_ackClr = w_ack ? (16'h0001 << r_ic) : 16'h0000;

  // Edge bits: clears first, then a fresh rise wins. Level bits track the sample.
  assign w_pendNext = ((r_edge & ((r_pend & ~w_w1c & ~w_ackClr) | w_rise))
                      | (~r_edge & w_srcSmp)) & VALID_MASK;

  irqc_prio_enc #(
    .NSRC(NSRC)
  ) u_prio (
    .i_req  (w_active[NSRC-1:0]),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_prev <= '0;
    end else begin
      r_pend <= w_pendNext;
      r_prev <= w_srcSmp;
      if (w_wrHit && (w_off == OFF_MASK)) r_mask <= D & VALID_MASK;
      if (w_wrHit && (w_off == OFF_EDGE)) r_edge <= D & VALID_MASK;
    end
  end

  // IC only loads on IDLE->REQ, so it stays frozen through REQ and SERV.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_ic    <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= REQ;
            r_ic    <= w_idx;
          end
        end
        REQ: begin
          if (w_ack)         r_state <= SERV;
          else if (!w_valid) r_state <= IDLE;
        end
        SERV: begin
          if (w_eoi) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdData = 16'h0000;
    case (w_off)
      OFF_PEND:  w_rdData = r_pend;
      OFF_MASK:  w_rdData = r_mask;
      OFF_CAUSE: w_rdData = causeWord(r_state == SERV, r_ic);
      OFF_EDGE:  w_rdData = r_edge;
      default:   w_rdData = 16'h0000;
    endcase
  end

  assign D   = w_rdHit ? w_rdData : 16'hzzzz;
  assign IRQ = (r_state == REQ);
  assign IC  = r_ic;

endmodule

`default_nettype wire
